l2_pool: RTL and testbench

L2_POOL -- requirements
Module: l2_pool

---
 rtl/l2_pool.sv | 127 ++++++++++++
 tb/tb_l2_pool.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_pool.sv
// 2x2 max-pool stage for four ReLU channels: pools one window per beat into a
// 25-entry frame buffer, with a registered read port and overflow tracking.
module l2_pool #(
  parameter int DATA_W = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_vld,
  input  logic [3:0][DATA_W-1:0] din_0,
  input  logic [3:0][DATA_W-1:0] din_1,
  input  logic [3:0][DATA_W-1:0] din_2,
  input  logic [3:0][DATA_W-1:0] din_3,
  input  logic                   tx_done,
  input  logic                   rd_en,
  input  logic [4:0]             rd_addr,
  output logic [3:0][DATA_W-1:0] dout,
  output logic                   dout_vld,
  output logic                   full,
  output logic                   ovf,
  output logic [4:0]             win_cnt
);

  localparam int NWIN = 25;
  localparam logic [4:0] LAST_WIN = 5'd24;
  localparam logic [4:0] NWIN_C   = 5'd25;

  typedef enum logic {ST_FILL = 1'b0, ST_FULL = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [4:0]               win_cnt_q, win_cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     wr_en;
  logic [3:0][DATA_W-1:0]   pool;
  logic [3:0][DATA_W-1:0]   mem_q [NWIN];
  logic [3:0][DATA_W-1:0]   dout_q, dout_d;
  logic                     dout_vld_q, dout_vld_d;

  // Unsigned max; strict '>' keeps the lowest-index element on ties.
  function automatic logic [DATA_W-1:0] max4(input logic [3:0][DATA_W-1:0] w);
    logic [DATA_W-1:0] m;
    m = w[0];
    for (int i = 1; i < 4; i++) begin
      if (w[i] > m) m = w[i];
    end
    return m;
  endfunction

  always_comb begin
    pool[0] = max4(din_0);
    pool[1] = max4(din_1);
    pool[2] = max4(din_2);
    pool[3] = max4(din_3);
  end

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      win_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // tx_done has priority over any beat arriving in the same cycle.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    ovf_d     = ovf_q;
    if (tx_done) begin
      state_d   = ST_FILL;
      win_cnt_d = '0;
      ovf_d     = 1'b0;
    end else if (in_vld) begin
      case (state_q)
        ST_FILL: begin
          if (win_cnt_q >= LAST_WIN) begin
            win_cnt_d = NWIN_C;
            state_d   = ST_FULL;
          end else begin
            win_cnt_d = win_cnt_q + 5'd1;
          end
        end
        ST_FULL: ovf_d = 1'b1;
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_comb begin
    full  = (state_q == ST_FULL);
    wr_en = in_vld && !tx_done && (state_q == ST_FILL) && (win_cnt_q < NWIN_C);
  end

  // Buffer is not reset; contents survive reset and frame clears.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[win_cnt_q] <= pool;
  end

  always_comb begin
    dout_d     = dout_q;
    dout_vld_d = rd_en;
    if (rd_en) begin
      dout_d = (rd_addr < NWIN_C) ? mem_q[rd_addr] : '0;
    end
  end

  // Read port register; nonblocking update gives read-before-write on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign ovf      = ovf_q;
  assign win_cnt  = win_cnt_q;

endmodule

// File: tb/tb_l2_pool.sv
// Directed bench for l2_pool: pooling vectors from a table, then hand-written
// frame, overflow, collision, reset and out-of-range sequences.
module tb_l2_pool;

  localparam int DATA_W = 18;
  localparam logic [17:0] MAXV = 18'h3FFFF;

  typedef logic [3:0][DATA_W-1:0] win_t;

  typedef struct {
    win_t d0;
    win_t d1;
    win_t d2;
    win_t d3;
    win_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  win_t        din_0 = '0, din_1 = '0, din_2 = '0, din_3 = '0;
  logic        tx_done = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_addr = '0;
  win_t        dout;
  logic        dout_vld;
  logic        full;
  logic        ovf;
  logic [4:0]  win_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  vec_t vecs [4];

  l2_pool #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .din_0    (din_0),
    .din_1    (din_1),
    .din_2    (din_2),
    .din_3    (din_3),
    .tx_done  (tx_done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .dout     (dout),
    .dout_vld (dout_vld),
    .full     (full),
    .ovf      (ovf),
    .win_cnt  (win_cnt)
  );

  always #5 clk = ~clk;

  function automatic win_t pk(input logic [17:0] e0, input logic [17:0] e1,
                              input logic [17:0] e2, input logic [17:0] e3);
    win_t r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
    return r;
  endfunction

  function automatic win_t splat(input logic [17:0] v);
    return pk(v, v, v, v);
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input win_t a, input win_t b, input win_t c, input win_t d);
    din_0 = a; din_1 = b; din_2 = c; din_3 = d;
    in_vld = 1'b1;
    step();
    in_vld = 1'b0;
  endtask

  task automatic read(input logic [4:0] addr);
    rd_en = 1'b1;
    rd_addr = addr;
    step();
    rd_en = 1'b0;
  endtask

  task automatic clear();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    vecs[0] = '{d0: pk(5, 9, 2, 9), d1: '0, d2: '0, d3: '0, exp: pk(9, 0, 0, 0)};
    vecs[1] = '{d0: pk(MAXV, 0, 1, 2), d1: pk(0, 0, 0, MAXV),
                d2: pk(18'h20000, 18'h1FFFF, 0, 0), d3: pk(7, 7, 7, 7),
                exp: pk(MAXV, MAXV, 18'h20000, 7)};
    vecs[2] = '{d0: pk(1, 2, 3, 4), d1: pk(4, 3, 2, 1), d2: pk(0, 100, 0, 50),
                d3: pk(18'h3FFFE, MAXV, 18'h3FFFD, 0), exp: pk(4, 4, 100, MAXV)};
    vecs[3] = '{d0: pk(0, 0, 0, 0), d1: pk(18'h10, 18'h2, 18'h10, 18'h3),
                d2: pk(18'h2AAAA, 18'h15555, 18'h2AAAB, 18'h1), d3: pk(3, 18'h20001, 8, 18'h1FFFF),
                exp: pk(0, 18'h10, 18'h2AAAB, 18'h20001)};

    // Reset state
    #3;
    chk("rst_dout", 72'(dout), 72'd0);
    chk("rst_vld", 72'(dout_vld), 72'd0);
    chk("rst_full", 72'(full), 72'd0);
    chk("rst_ovf", 72'(ovf), 72'd0);
    chk("rst_cnt", 72'(win_cnt), 72'd0);
    #5 rst_n = 1'b1;
    step();

    // Table-driven pooling vectors, each in a fresh frame at buf[0]
    for (int i = 0; i < 4; i++) begin
      clear();
      beat(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3);
      chk($sformatf("vec%0d_cnt", i), 72'(win_cnt), 72'd1);
      chk($sformatf("vec%0d_vld_pre", i), 72'(dout_vld), 72'd0);
      read(5'd0);
      chk($sformatf("vec%0d_vld", i), 72'(dout_vld), 72'd1);
      chk($sformatf("vec%0d_dout", i), 72'(dout), 72'(vecs[i].exp));
      step();
      chk($sformatf("vec%0d_vld_drop", i), 72'(dout_vld), 72'd0);
      chk($sformatf("vec%0d_hold", i), 72'(dout), 72'(vecs[i].exp));
    end

    // Full frame of 25 windows
    clear();
    for (int k = 0; k < 25; k++) begin
      beat(splat(18'(k)), splat(18'(k)), splat(18'(k)), splat(18'(k)));
      if (k == 23) chk("frame_full_early", 72'(full), 72'd0);
    end
    chk("frame_full", 72'(full), 72'd1);
    chk("frame_cnt", 72'(win_cnt), 72'd25);
    chk("frame_ovf", 72'(ovf), 72'd0);
    for (int k = 0; k < 25; k++) begin
      read(5'(k));
      chk($sformatf("frame_rd%0d", k), 72'(dout), 72'(splat(18'(k))));
    end

    // Overflow beat while full
    beat(splat(MAXV), splat(MAXV), splat(MAXV), splat(MAXV));
    chk("ovf_set", 72'(ovf), 72'd1);
    chk("ovf_cnt", 72'(win_cnt), 72'd25);
    chk("ovf_full", 72'(full), 72'd1);
    read(5'd24);
    chk("ovf_buf24", 72'(dout), 72'(splat(18'd24)));
    clear();
    chk("clr_full", 72'(full), 72'd0);
    chk("clr_ovf", 72'(ovf), 72'd0);
    chk("clr_cnt", 72'(win_cnt), 72'd0);
    read(5'd24);
    chk("clr_buf24", 72'(dout), 72'(splat(18'd24)));

    // tx_done and in_vld together at win_cnt=3: beat dropped
    for (int k = 0; k < 3; k++) begin
      beat(splat(18'(100 + k)), splat(18'(100 + k)), splat(18'(100 + k)), splat(18'(100 + k)));
    end
    chk("col_cnt3", 72'(win_cnt), 72'd3);
    tx_done = 1'b1;
    beat(splat(18'h555), splat(18'h555), splat(18'h555), splat(18'h555));
    tx_done = 1'b0;
    chk("col_cnt0", 72'(win_cnt), 72'd0);
    read(5'd3);
    chk("col_buf3", 72'(dout), 72'(splat(18'd3)));

    // Same-address read and write: old data returned, then new
    rd_en = 1'b1;
    rd_addr = 5'd0;
    beat(splat(18'd200), splat(18'd201), splat(18'd202), splat(18'd203));
    rd_en = 1'b0;
    chk("rbw_old", 72'(dout), 72'(splat(18'd100)));
    chk("rbw_cnt", 72'(win_cnt), 72'd1);
    read(5'd0);
    chk("rbw_new", 72'(dout), 72'(pk(200, 201, 202, 203)));

    // Asynchronous reset mid-frame at win_cnt=12
    clear();
    for (int k = 0; k < 12; k++) begin
      beat(splat(18'(50 + k)), splat(18'(50 + k)), splat(18'(50 + k)), splat(18'(50 + k)));
    end
    chk("ar_cnt12", 72'(win_cnt), 72'd12);
    rd_en = 1'b1;
    rd_addr = 5'd5;
    step();
    chk("ar_pre_dout", 72'(dout), 72'(splat(18'd55)));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_dout", 72'(dout), 72'd0);
    chk("ar_vld", 72'(dout_vld), 72'd0);
    chk("ar_cnt", 72'(win_cnt), 72'd0);
    chk("ar_full", 72'(full), 72'd0);
    chk("ar_ovf", 72'(ovf), 72'd0);
    rd_en = 1'b0;
    #2 rst_n = 1'b1;
    step();
    beat(splat(18'd77), splat(18'd78), splat(18'd79), splat(18'd80));
    chk("ar_next_cnt", 72'(win_cnt), 72'd1);
    read(5'd0);
    chk("ar_next_buf0", 72'(dout), 72'(pk(77, 78, 79, 80)));

    // Out-of-range reads
    read(5'd31);
    chk("oor31_vld", 72'(dout_vld), 72'd1);
    chk("oor31_dout", 72'(dout), 72'd0);
    read(5'd0);
    read(5'd25);
    chk("oor25_dout", 72'(dout), 72'd0);
    chk("oor_cnt", 72'(win_cnt), 72'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
